branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequences the conditional ALU (cond ALU) for branch resolution.
- Accepts one branch request at a time from decode over a valid/ready handshake, and latches the operands.
- Drives the cond ALU inputs for one evaluation cycle, then issues a PC redirect and a timed pipeline flush on taken branches.
- Resolves the two reserved condition codes, always-false (ALU_F) and always-true (ALU_T), locally; maintains saturating branch/taken performance counters.

Parameters:
- PC_W, 32, width of PC, offset and target.
- FLUSH_CYCLES, 2, cycles flush is held after a redirect is accepted (legal range 1..15).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  decode presents a branch.
- br_ready  out  1  controller can accept a branch.
- br_op  in  4  condition code, from the shared `ALU_* set.
- br_opa  in  32  first operand, signed.
- br_opb  in  32  second operand, signed.
- br_pc  in  PC_W  PC of the branch.
- br_offset  in  PC_W  signed word offset.
- kill  in  1  exception/abort; cancels the branch in flight.
- cond_opa  out  32  to cond ALU opa.
- cond_opb  out  32  to cond ALU opb.
- cond_op  out  4  to cond ALU op.
- cond_z  in  1  cond ALU z_flag, combinational from cond_*.
- redirect_valid  out  1  new PC available.
- redirect_pc  out  PC_W  branch target.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  squash younger pipeline stages.
- res_valid  out  1  one-cycle pulse when the branch retires.
- res_taken  out  1  outcome; qualified by res_valid.
- ctr_clr  in  1  clears both counters.
- br_count  out  CNT_W  resolved branches, saturating.
- taken_count  out  CNT_W  taken branches, saturating.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high (rst). rst overrides every other input, including mid-operation.
- Reset values: state=IDLE; all latches 0; counters 0; br_ready=1; redirect_valid=0; flush=0; res_valid=0; res_taken=0.
- cond_* come from the latched registers, not the br_* inputs. They are stable throughout EVAL and 0 in IDLE.
- IDLE:
  - br_ready=1.
  - br_valid&br_ready (handshake) -> latch op/opa/opb/pc/offset, go to EVAL.
  - kill has no effect in IDLE.
- EVAL (exactly 1 cycle):
  - br_ready=0.
  - taken = 0 if op==`ALU_F; 1 if op==`ALU_T; otherwise cond_z.
  - target = pc + (sign-extended offset << 2), truncated to PC_W; wraps modulo 2^PC_W.
  - Register taken and target.
  - taken -> REDIRECT. Not taken -> res_valid=1, res_taken=0 next cycle, then IDLE.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target.
  - Both held stable until redirect_ready is sampled high.
  - On that handshake cycle -> FLUSH, load flush counter with FLUSH_CYCLES.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - On the last flush cycle: res_valid=1, res_taken=1; next state IDLE.
  - br_ready is asserted only once back in IDLE; back-to-back acceptance is not allowed.
- Latency:
  - Accept in cycle N; EVAL in N+1.
  - Not taken: res_valid in N+2.
  - Taken with redirect_ready tied high: redirect_valid in N+2; flush in N+3..N+2+FLUSH_CYCLES.
- kill in EVAL/REDIRECT/FLUSH:
  - Next cycle state=IDLE; redirect_valid, flush and res_valid all 0.
  - No counter update. The killed branch is discarded.
  - kill wins over a simultaneous redirect_ready.
- Counters:
  - br_count increments on every res_valid pulse; taken_count increments when res_valid&res_taken.
  - Both saturate at 2^CNT_W-1.
  - ctr_clr has priority over an increment in the same cycle; result 0.
- Undefined op codes (not in the `ALU_* set) give cond_z=0 and are resolved as not taken.

Decomposition:
- The `ALU_* condition codes stay in the shared params include; ALU_F and ALU_T are used from there.
- Add to the same include:
  - state encodings BR_IDLE, BR_EVAL, BR_REDIRECT, BR_FLUSH;
  - the offset shift constant (2).
- One sub-module is natural: br_sat_counter (CNT_W, inc, clr), instantiated twice.
- The cond ALU is instantiated at the level above, not inside branch_ctrl.

Test Plan:
- `ALU_EQ, opa=5, opb=5, pc=0x100, offset=4, redirect_ready=1 -> redirect_pc=0x110 at N+2; flush high 2 cycles; res_taken=1; br_count=1, taken_count=1.
- `ALU_LT, opa=3, opb=-1 -> not taken; res_valid at N+2, res_taken=0, no redirect, no flush; br_ready high again at N+3.
- `ALU_T with opa=opb=0, then `ALU_F -> first taken regardless of cond_z; second not taken; taken_count=1, br_count=2.
- `ALU_GTZ taken, redirect_ready held low 5 cycles -> redirect_valid and redirect_pc stable all 5 cycles; flush starts the cycle after redirect_ready rises.
- pc=0xFFFFFFF8, offset=4 -> target wraps to 0x00000008.
- kill asserted in REDIRECT together with redirect_ready -> IDLE next cycle, no flush, counters unchanged.
- Preload counters to 0xFFFF, resolve a taken branch -> both stay 0xFFFF; ctr_clr together with an increment -> both 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared branch-controller definitions: cond ALU condition codes, FSM encodings,
// the latched operand record and the local resolution of the reserved codes.
package branch_ctrl_pkg;

  // Condition codes of the cond ALU; ALU_F / ALU_T are resolved locally.
  localparam logic [3:0] ALU_F   = 4'h0;
  localparam logic [3:0] ALU_EQ  = 4'h1;
  localparam logic [3:0] ALU_NE  = 4'h2;
  localparam logic [3:0] ALU_LT  = 4'h3;
  localparam logic [3:0] ALU_GE  = 4'h4;
  localparam logic [3:0] ALU_LTU = 4'h5;
  localparam logic [3:0] ALU_GEU = 4'h6;
  localparam logic [3:0] ALU_GTZ = 4'h7;
  localparam logic [3:0] ALU_LEZ = 4'h8;
  localparam logic [3:0] ALU_LTZ = 4'h9;
  localparam logic [3:0] ALU_GEZ = 4'hA;
  localparam logic [3:0] ALU_T   = 4'hF;

  localparam int BR_OFF_SHIFT = 2;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_EVAL     = 2'd1,
    BR_REDIRECT = 2'd2,
    BR_FLUSH    = 2'd3
  } br_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
  } br_cond_t;

  function automatic logic br_resolve(input logic [3:0] op, input logic z);
    if (op == ALU_F)      return 1'b0;
    else if (op == ALU_T) return 1'b1;
    else                  return z;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode -> branch controller request channel (valid/ready).
interface branch_ctrl_if #(parameter int PC_W = 32);
  logic            br_valid;
  logic            br_ready;
  logic [3:0]      br_op;
  logic [31:0]     br_opa;
  logic [31:0]     br_opb;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] br_offset;

  modport master (
    output br_valid, br_op, br_opa, br_opb, br_pc, br_offset,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_op, br_opa, br_opb, br_pc, br_offset,
    output br_ready
  );
endinterface

// File: rtl/br_sat_counter.sv
// Saturating up-counter with clear-over-increment priority.
module br_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != '1)  count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: latches a decode request, drives the external cond ALU
// for one cycle, then redirects fetch and holds flush for taken branches.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_ctrl_if.slave     br,
  input  logic             kill,
  output logic [31:0]      cond_opa,
  output logic [31:0]      cond_opb,
  output logic [3:0]       cond_op,
  input  logic             cond_z,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  input  logic             ctr_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("branch_ctrl: FLUSH_CYCLES must be in 1..15");
  end

  br_state_e       state_q, state_d;
  br_cond_t        cond_q;
  logic [PC_W-1:0] pc_q, off_q, target_q;
  logic [3:0]      fcnt_q;
  logic            nt_pend_q;
  logic            accept, taken, last_flush;

  assign accept      = br.br_valid && br.br_ready;
  assign taken       = br_resolve(cond_q.op, cond_z);
  assign last_flush  = (state_q == BR_FLUSH) && (fcnt_q == 4'd1);
  assign redirect_pc = target_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill && state_q != BR_IDLE) begin
      state_d = BR_IDLE;
    end else begin
      case (state_q)
        BR_IDLE:     if (accept) state_d = BR_EVAL;
        BR_EVAL:     state_d = taken ? BR_REDIRECT : BR_IDLE;
        BR_REDIRECT: if (redirect_ready) state_d = BR_FLUSH;
        BR_FLUSH:    if (last_flush) state_d = BR_IDLE;
        default:     state_d = BR_IDLE;
      endcase
    end
  end

  // Not-taken results retire the cycle after EVAL while already in IDLE, so
  // nt_pend_q holds off br_ready for that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q    <= '0;
      pc_q      <= '0;
      off_q     <= '0;
      target_q  <= '0;
      fcnt_q    <= '0;
      nt_pend_q <= 1'b0;
    end else begin
      if (state_q == BR_IDLE && accept) begin
        cond_q <= '{op: br.br_op, opa: br.br_opa, opb: br.br_opb};
        pc_q   <= br.br_pc;
        off_q  <= br.br_offset;
      end
      if (state_q == BR_EVAL)
        target_q <= pc_q + (off_q << BR_OFF_SHIFT);
      nt_pend_q <= (state_q == BR_EVAL) && !taken && !kill;
      if (state_q == BR_REDIRECT && redirect_ready)
        fcnt_q <= 4'(FLUSH_CYCLES);
      else if (state_q == BR_FLUSH && fcnt_q != 4'd0)
        fcnt_q <= fcnt_q - 4'd1;
    end
  end

  always_comb begin
    br.br_ready    = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    res_valid      = nt_pend_q;
    res_taken      = 1'b0;
    cond_op        = '0;
    cond_opa       = '0;
    cond_opb       = '0;
    case (state_q)
      BR_IDLE:     br.br_ready = !nt_pend_q;
      BR_EVAL: begin
        cond_op  = cond_q.op;
        cond_opa = cond_q.opa;
        cond_opb = cond_q.opb;
      end
      BR_REDIRECT: redirect_valid = 1'b1;
      BR_FLUSH: begin
        flush = 1'b1;
        if (last_flush) begin
          res_valid = 1'b1;
          res_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  br_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res_valid),
    .clr   (ctr_clr),
    .count (br_count)
  );

  br_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res_valid && res_taken),
    .clr   (ctr_clr),
    .count (taken_count)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table for single branches plus hand-written
// kill / saturation / clear / reset sequences. Counters are 4 bits wide so saturation is reachable.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int PC_W = 32;
  localparam int FLC  = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            kill;
  logic [31:0]     cond_opa, cond_opb;
  logic [3:0]      cond_op;
  logic            cond_z;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush, res_valid, res_taken, ctr_clr;
  logic [CW-1:0]   br_count, taken_count;

  branch_ctrl_if #(.PC_W(PC_W)) bus ();

  branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FLC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .br(bus), .kill(kill),
    .cond_opa(cond_opa), .cond_opb(cond_opb), .cond_op(cond_op), .cond_z(cond_z),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
    .ctr_clr(ctr_clr), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  // Cond ALU model; F/T deliberately report the opposite of their meaning so the
  // controller must resolve them locally.
  function automatic logic alu_z(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_EQ:  return a == b;
      ALU_NE:  return a != b;
      ALU_LT:  return $signed(a) <  $signed(b);
      ALU_GE:  return $signed(a) >= $signed(b);
      ALU_LTU: return a <  b;
      ALU_GEU: return a >= b;
      ALU_GTZ: return $signed(a) >  0;
      ALU_LEZ: return $signed(a) <= 0;
      ALU_LTZ: return $signed(a) <  0;
      ALU_GEZ: return $signed(a) >= 0;
      ALU_F:   return 1'b1;
      ALU_T:   return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_z = alu_z(cond_op, cond_opa, cond_opb);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off);
    bus.br_valid  = 1'b1;
    bus.br_op     = op;
    bus.br_opa    = a;
    bus.br_opb    = b;
    bus.br_pc     = pc;
    bus.br_offset = off;
  endtask

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic do_branch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input int rdly,
                           input logic exp_tk, input logic [31:0] exp_tgt,
                           input int exp_bc, input int exp_tc);
    start(op, a, b, pc, off);
    @(negedge clk); chk("idle_ready", 32'(bus.br_ready), 1);
    tick();
    bus.br_valid = 1'b0;
    @(negedge clk);
    chk("eval_op", 32'(cond_op), 32'(op));
    chk("eval_opa", cond_opa, a);
    chk("eval_opb", cond_opb, b);
    chk("eval_ready", 32'(bus.br_ready), 0);
    tick();
    if (!exp_tk) begin
      @(negedge clk);
      chk("nt_res_valid", 32'(res_valid), 1);
      chk("nt_res_taken", 32'(res_taken), 0);
      chk("nt_redirect", 32'(redirect_valid), 0);
      chk("nt_flush", 32'(flush), 0);
      chk("nt_ready_low", 32'(bus.br_ready), 0);
      tick();
    end else begin
      for (int d = 0; d < rdly; d++) begin
        @(negedge clk);
        chk("rd_wait_valid", 32'(redirect_valid), 1);
        chk("rd_wait_pc", redirect_pc, exp_tgt);
        chk("rd_wait_flush", 32'(flush), 0);
        tick();
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      chk("rd_valid", 32'(redirect_valid), 1);
      chk("rd_pc", redirect_pc, exp_tgt);
      chk("rd_flush", 32'(flush), 0);
      tick();
      redirect_ready = 1'b0;
      for (int f = 0; f < FLC; f++) begin
        @(negedge clk);
        chk("fl_flush", 32'(flush), 1);
        chk("fl_redirect", 32'(redirect_valid), 0);
        chk("fl_res_valid", 32'(res_valid), (f == FLC - 1) ? 1 : 0);
        if (f == FLC - 1) chk("fl_res_taken", 32'(res_taken), 1);
        tick();
      end
    end
    @(negedge clk);
    chk("end_ready", 32'(bus.br_ready), 1);
    chk("end_flush", 32'(flush), 0);
    chk("end_res_valid", 32'(res_valid), 0);
    chk("br_count", 32'(br_count), exp_bc);
    chk("taken_count", 32'(taken_count), exp_tc);
    tick();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pc, off;
    int          rdly;
    logic        tk;
    logic [31:0] tgt;
    int          bc, tc;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{ALU_EQ,  32'd5,  32'd5,          32'h100,      32'd4,          0, 1'b1, 32'h110,      1, 1};
    vt[1] = '{ALU_LT,  32'd3,  32'hFFFF_FFFF,  32'h100,      32'd4,          0, 1'b0, 32'h0,        2, 1};
    vt[2] = '{ALU_T,   32'd0,  32'd0,          32'h200,      32'hFFFF_FFFF,  0, 1'b1, 32'h1FC,      3, 2};
    vt[3] = '{ALU_F,   32'd7,  32'd7,          32'h300,      32'd1,          0, 1'b0, 32'h0,        4, 2};
    vt[4] = '{ALU_GTZ, 32'd5,  32'd0,          32'h40,       32'h10,         5, 1'b1, 32'h80,       5, 3};
    vt[5] = '{ALU_EQ,  32'd1,  32'd1,          32'hFFFF_FFF8, 32'd4,         0, 1'b1, 32'h8,        6, 4};
    vt[6] = '{4'hC,    32'd9,  32'd9,          32'h500,      32'd1,          0, 1'b0, 32'h0,        7, 4};
    vt[7] = '{ALU_NE,  32'd1,  32'd2,          32'h1000,     32'hFFFF_FFFE,  1, 1'b1, 32'hFF8,      8, 5};
    vt[8] = '{ALU_GE,  32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0,  32'd1,          0, 1'b1, 32'h4,        9, 6};

    rst = 1'b1; kill = 1'b0; redirect_ready = 1'b0; ctr_clr = 1'b0;
    bus.br_valid = 1'b0; bus.br_op = '0; bus.br_opa = '0; bus.br_opb = '0;
    bus.br_pc = '0; bus.br_offset = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.br_ready), 1);
    chk("rst_redirect", 32'(redirect_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_taken", 32'(res_taken), 0);
    chk("rst_cond_op", 32'(cond_op), 0);
    chk("rst_br_count", 32'(br_count), 0);
    chk("rst_taken_count", 32'(taken_count), 0);
    tick();

    foreach (vt[i])
      do_branch(vt[i].op, vt[i].a, vt[i].b, vt[i].pc, vt[i].off, vt[i].rdly,
                vt[i].tk, vt[i].tgt, vt[i].bc, vt[i].tc);

    // kill together with redirect_ready in REDIRECT
    start(ALU_EQ, 32'd1, 32'd1, 32'h0, 32'd1);
    tick(); bus.br_valid = 1'b0;
    tick();
    @(negedge clk); chk("k_rd_valid", 32'(redirect_valid), 1);
    tick(); kill = 1'b1; redirect_ready = 1'b1;
    tick(); kill = 1'b0; redirect_ready = 1'b0;
    @(negedge clk);
    chk("k_rd_redirect", 32'(redirect_valid), 0);
    chk("k_rd_flush", 32'(flush), 0);
    chk("k_rd_res_valid", 32'(res_valid), 0);
    chk("k_rd_ready", 32'(bus.br_ready), 1);
    tick();
    @(negedge clk);
    chk("k_rd_flush2", 32'(flush), 0);
    chk("k_rd_br_count", 32'(br_count), 9);
    chk("k_rd_taken_count", 32'(taken_count), 6);
    tick();

    // kill in EVAL of a not-taken branch: no result pulse
    start(ALU_LT, 32'd4, 32'd1, 32'h0, 32'd1);
    tick(); bus.br_valid = 1'b0; kill = 1'b1;
    tick(); kill = 1'b0;
    @(negedge clk);
    chk("k_ev_res_valid", 32'(res_valid), 0);
    chk("k_ev_redirect", 32'(redirect_valid), 0);
    chk("k_ev_ready", 32'(bus.br_ready), 1);
    tick();

    // kill in the first FLUSH cycle
    redirect_ready = 1'b1;
    start(ALU_T, 32'd0, 32'd0, 32'h0, 32'd1);
    tick(); bus.br_valid = 1'b0;
    tick();
    tick(); redirect_ready = 1'b0; kill = 1'b1;
    @(negedge clk); chk("k_fl_flush_on", 32'(flush), 1);
    tick(); kill = 1'b0;
    @(negedge clk);
    chk("k_fl_flush", 32'(flush), 0);
    chk("k_fl_res_valid", 32'(res_valid), 0);
    chk("k_fl_ready", 32'(bus.br_ready), 1);
    tick();
    @(negedge clk);
    chk("k_fl_br_count", 32'(br_count), 9);
    chk("k_fl_taken_count", 32'(taken_count), 6);
    tick();

    // saturation at 2^CW-1
    for (int i = 0; i < 10; i++)
      do_branch(ALU_T, 32'd0, 32'd0, 32'h10, 32'd1, 0, 1'b1, 32'h14,
                (10 + i > 15) ? 15 : 10 + i, (7 + i > 15) ? 15 : 7 + i);

    // ctr_clr in the same cycle as a result pulse
    start(ALU_LT, 32'd5, 32'd1, 32'h0, 32'd1);
    tick(); bus.br_valid = 1'b0;
    tick(); ctr_clr = 1'b1;
    @(negedge clk); chk("clr_res_valid", 32'(res_valid), 1);
    tick(); ctr_clr = 1'b0;
    @(negedge clk);
    chk("clr_br_count", 32'(br_count), 0);
    chk("clr_taken_count", 32'(taken_count), 0);
    tick();
    do_branch(ALU_EQ, 32'd2, 32'd2, 32'h20, 32'd2, 0, 1'b1, 32'h28, 1, 1);

    // reset while in REDIRECT
    start(ALU_T, 32'd0, 32'd0, 32'h0, 32'd3);
    tick(); bus.br_valid = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_redirect", 32'(redirect_valid), 0);
    chk("mrst_pc", redirect_pc, 0);
    chk("mrst_ready", 32'(bus.br_ready), 1);
    chk("mrst_br_count", 32'(br_count), 0);
    chk("mrst_taken_count", 32'(taken_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
